// File: rtl/misr_pkg.sv
// Shared types and constants for the MISR signature unit.
package misr_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'b00,
        COMPRESS = 2'b01,
        SCAN     = 2'b10,
        LOAD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        DONE
    } state_e;

    localparam logic [31:0] DEFAULT_POLY = 32'h0000_8409;

endpackage

// File: rtl/misr_step.sv
// One MISR compression step: shift left, fold the MSB back through the taps, absorb din.
module misr_step
    import misr_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(DEFAULT_POLY)
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] next
);

    assign next = {sig[WIDTH-2:0], 1'b0} ^ din ^ (POLY & {WIDTH{sig[WIDTH-1]}});

endmodule

// File: rtl/misr_signature_unit.sv
// MISR with a session controller: seeds, compresses a fixed number of beats,
// then reports the golden comparison; also supports scan shifting and seed loading.
module misr_signature_unit
    import misr_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
    parameter int               CNT_W = 16
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             TM1,
    input  logic             TM0,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [CNT_W-1:0] length,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] golden,
    input  logic             scan_in,
    output logic             scan_out,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             pass_q, pass_d;

    mode_e            mode;
    logic [WIDTH-1:0] stepNext;
    logic [CNT_W-1:0] cntInc;

    assign mode   = mode_e'({TM1, TM0});
    assign cntInc = cnt_q + CNT_W'(1);

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .sig  (sig_q),
        .din  (din),
        .next (stepNext)
    );

    always_ff @(posedge CK) begin
        if (RESET) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
        end
    end

    // Any mode other than COMPRESS ends a running session; LOAD and SCAN also leave DONE.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        pass_d  = pass_q;
        case (mode)
            LOAD: begin
                sig_d   = seed;
                state_d = IDLE;
                pass_d  = 1'b0;
            end
            SCAN: begin
                state_d = IDLE;
                pass_d  = 1'b0;
                if (state_q != COMPACT) begin
                    sig_d = {sig_q[WIDTH-2:0], scan_in};
                end
            end
            HOLD: begin
                if (state_q == COMPACT) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end
            end
            COMPRESS: begin
                if (state_q == COMPACT) begin
                    if (din_valid) begin
                        sig_d = stepNext;
                        cnt_d = cntInc;
                        if (cntInc == len_q) begin
                            state_d = DONE;
                            pass_d  = (stepNext == golden);
                        end
                    end
                end else if (start) begin
                    sig_d = seed;
                    cnt_d = '0;
                    len_d = length;
                    if (length == '0) begin
                        state_d = DONE;
                        pass_d  = (seed == golden);
                    end else begin
                        state_d = COMPACT;
                        pass_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign signature = sig_q;
    assign scan_out  = sig_q[WIDTH-1];
    assign busy      = (state_q == COMPACT);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;

endmodule
